// File: rtl/led_scan_driver.sv
// Multiplexed scan driver for an up-to-8-digit 7-segment display.
// Each digit slot is a blanking gap followed by a drive phase, with optional leading-zero suppression.
module led_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_enable,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_addr,
  input  logic [4:0] i_wr_data,
  input  logic       i_lz_en,
  output logic [4:0] o_dig_ctrl,
  output logic [7:0] o_dig_an,
  output logic       o_frame_start
);

  localparam int CW = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam int IW = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [4:0]      dig_ctrl_nx;
  logic [7:0]      dig_an_nx;
  logic            frame_nx;

  logic [4:0]            digit_buf [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_tail;

  // Digit buffer: host writes land in any state, including while the scan is disabled.
  // NOTE: this small register file is reset on purpose; the display must come up blank, not random.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) digit_buf[k] <= 5'h00;
    end else if (i_wr_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (i_wr_addr == 3'(k)) digit_buf[k] <= i_wr_data;
      end
    end
  end

  // A digit is suppressed when it and every higher digit hold 5'h00; digit 0 always shows.
  // NOTE: blocking assignments here are deliberate; zero_tail accumulates down the loop within one evaluation.
  always_comb begin
    zero_tail = 1'b1;
    supp      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_tail = zero_tail && (digit_buf[k] == 5'h00);
      supp[k]   = i_lz_en && zero_tail && (k != 0);
    end
  end

  // Next-state and next-output logic; outputs are computed one step ahead and registered below.
  // NOTE: every target gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 1'b1;
    idx_nx      = idx;
    dig_ctrl_nx = o_dig_ctrl;
    dig_an_nx   = o_dig_an;
    frame_nx    = 1'b0;

    if (!i_enable) begin
      state_nx  = S_BLANK;
      cnt_nx    = '0;
      idx_nx    = '0;
      dig_an_nx = 8'hFF;
    end else begin
      case (state)
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx    = S_DRIVE;
            dig_ctrl_nx = digit_buf[idx];
            dig_an_nx   = supp[idx] ? 8'hFF : ~(8'h01 << idx);
            frame_nx    = (idx == '0);
          end
        end
        S_DRIVE: begin
          if (cnt == SLOT_LAST) begin
            state_nx  = S_BLANK;
            cnt_nx    = '0;
            idx_nx    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            dig_an_nx = 8'hFF;
          end
        end
        default: begin
          state_nx  = S_BLANK;
          cnt_nx    = '0;
          idx_nx    = '0;
          dig_an_nx = 8'hFF;
        end
      endcase
    end
  end

  // State and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_BLANK;
      cnt           <= '0;
      idx           <= '0;
      o_dig_ctrl    <= 5'h00;
      o_dig_an      <= 8'hFF;
      o_frame_start <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      idx           <= idx_nx;
      o_dig_ctrl    <= dig_ctrl_nx;
      o_dig_an      <= dig_an_nx;
      o_frame_start <= frame_nx;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver: directed scenarios plus random traffic,
// compared every cycle against a slot-timeline reference model.
module tb_led_scan_driver;

  localparam int ND = 8;
  localparam int SD = 4;
  localparam int BC = 1;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       lz_en;
  logic [4:0] dig_ctrl;
  logic [7:0] dig_an;
  logic       frame_start;

  led_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (enable),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_lz_en      (lz_en),
    .o_dig_ctrl   (dig_ctrl),
    .o_dig_an     (dig_an),
    .o_frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: n = edges since the scan (re)started; the slot position and digit follow from it.
  logic [4:0] mbuf [ND];
  int         n;
  logic [4:0] exp_ctrl;
  logic       exp_supp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_p();
    return n % SD;
  endfunction

  function automatic int cur_d();
    return (n / SD) % ND;
  endfunction

  function automatic logic tail_zero(input int k);
    for (int j = k; j < ND; j++) if (mbuf[j] != 5'h00) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) mbuf[k] = 5'h00;
    n        = 0;
    exp_ctrl = 5'h00;
    exp_supp = 1'b0;
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then compare outputs 1 time unit later.
  task automatic step();
    logic       en_s, we_s, lz_s;
    logic [2:0] wa_s;
    logic [4:0] wd_s;
    logic [7:0] exp_an;
    logic       exp_fs;
    en_s = enable; we_s = wr_en; lz_s = lz_en; wa_s = wr_addr; wd_s = wr_data;
    @(posedge clk);
    if (!en_s) begin
      n = 0;
    end else begin
      n++;
      if (cur_p() == BC) begin
        exp_ctrl = mbuf[cur_d()];
        exp_supp = lz_s && (cur_d() != 0) && tail_zero(cur_d());
      end
    end
    if (we_s && int'(wa_s) < ND) mbuf[int'(wa_s)] = wd_s;
    exp_an = 8'hFF;
    if (cur_p() >= BC && !exp_supp) exp_an = 8'hFF ^ (8'd1 << cur_d());
    exp_fs = en_s && (cur_p() == BC) && (cur_d() == 0);
    #1;
    check("anode", 32'(dig_an), 32'(exp_an));
    check("ctrl", 32'(dig_ctrl), 32'(exp_ctrl));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
  endtask

  task automatic write_digit(input logic [2:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run_until(input int digit, input logic drive, input string tag);
    int   guard;
    logic timed_out;
    guard = 0;
    timed_out = 1'b0;
    while (!(cur_d() == digit && ((cur_p() >= BC) == drive)) && !timed_out) begin
      step();
      guard++;
      if (guard > 200) timed_out = 1'b1;
    end
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
  endtask

  initial begin
    enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; lz_en = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Reset state, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_anode", 32'(dig_an), 32'hFF);
    check("rst_ctrl", 32'(dig_ctrl), 32'h00);
    check("rst_frame", 32'(frame_start), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    enable = 1'b1;

    // Startup: one blank cycle, FE for three cycles with a frame pulse, blank, FD.
    step();
    check("start_first_drive", 32'(dig_an), 32'hFE);
    check("start_first_pulse", 32'(frame_start), 32'h1);
    repeat (10) step();

    // Counting pattern, two full frames.
    for (int k = 0; k < ND; k++) write_digit(3'(k), 5'(k + 1));
    repeat (2 * ND * SD) step();

    // Leading-zero suppression: only digits 1 and 0 light.
    for (int k = 2; k < ND; k++) write_digit(3'(k), 5'h00);
    write_digit(3'd1, 5'h13);
    write_digit(3'd0, 5'h00);
    lz_en = 1'b1;
    repeat (2 * ND * SD) step();
    run_until(2, 1'b1, "lz_d2");
    check("lz_d2_anode", 32'(dig_an), 32'hFF);
    run_until(1, 1'b1, "lz_d1");
    check("lz_d1_anode", 32'(dig_an), 32'hFD);
    check("lz_d1_ctrl", 32'(dig_ctrl), 32'h13);
    run_until(0, 1'b1, "lz_d0");
    check("lz_d0_anode", 32'(dig_an), 32'hFE);
    check("lz_d0_ctrl", 32'(dig_ctrl), 32'h00);
    lz_en = 1'b0;
    repeat (ND * SD + SD) step();
    run_until(7, 1'b1, "nolz_d7");
    check("nolz_d7_anode", 32'(dig_an), 32'h7F);

    // Write to digit 3 while it is being driven: visible only on the next frame.
    run_until(3, 1'b1, "wr_d3");
    write_digit(3'd3, 5'h0A);
    check("wr_same_slot", 32'(dig_ctrl), 32'h00);
    run_until(4, 1'b1, "wr_d4");
    run_until(3, 1'b1, "wr_next");
    check("wr_next_frame", 32'(dig_ctrl), 32'h0A);

    // Disable during digit 5 drive, then re-enable.
    run_until(5, 1'b1, "dis_d5");
    enable = 1'b0;
    step();
    check("dis_dark", 32'(dig_an), 32'hFF);
    repeat (3) step();
    enable = 1'b1;
    step();
    check("reen_drive", 32'(dig_an), 32'hFE);
    check("reen_pulse", 32'(frame_start), 32'h1);

    // Random traffic: sparse data to exercise suppression, lz toggles, enable drops.
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20) begin
        write_digit(3'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00);
      end else if (r < 23) begin
        lz_en = ~lz_en;
        step();
      end else if (r < 25) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 6)) step();
        enable = 1'b1;
        step();
      end else begin
        step();
      end
    end

    // Asynchronous reset between edges in the middle of a drive phase.
    lz_en = 1'b0;
    for (int k = 0; k < ND; k++) write_digit(3'(k), 5'h15);
    run_until(2, 1'b1, "arst_d2");
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_anode", 32'(dig_an), 32'hFF);
    check("arst_ctrl", 32'(dig_ctrl), 32'h00);
    check("arst_frame", 32'(frame_start), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= ND; k++) begin
      run_until(k % ND, 1'b1, "arst_rb");
      check("arst_readback", 32'(dig_ctrl), 32'h00);
    end
    repeat (ND * SD) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
